// File: rtl/traffic_pkg.sv
// Shared mode encoding for the traffic mode controller and its sequencer consumers.
package traffic_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_NIGHT = 2'b00;
    localparam mode_t MODE_DAY   = 2'b01;
    localparam mode_t MODE_PED   = 2'b10;
    localparam mode_t MODE_EMG   = 2'b11;

endpackage

// File: rtl/traffic_dwell_counter.sv
// Saturating dwell counter with synchronous clear and asynchronous active-high reset.
module traffic_dwell_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/traffic_mode_ctrl.sv
// Registered traffic mode selector with dwell, pedestrian phase and emergency clearance.
// Optional sticky pedestrian request latch enabled by defining TRAFFIC_PED_LATCH_EN.
module traffic_mode_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_DWELL = 8,
    parameter int unsigned PED_TIME  = 4,
    parameter int unsigned EMG_CLEAR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             time_sig,
    input  logic             ped_req,
    input  logic             emg_req,
    output mode_t            mode,
    output logic             mode_change,
    output logic             ped_ack,
    output logic [CNT_W-1:0] dwell_cnt
);

    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(MIN_DWELL - 1);
    localparam logic [CNT_W-1:0] PedLast   = CNT_W'(PED_TIME - 1);
    localparam logic [CNT_W-1:0] EmgLast   = CNT_W'(EMG_CLEAR);

    mode_t mode_next;
    mode_t base;
    logic  ped_pend;
    logic  enter_ped;
    logic  cnt_clr;

    assign base      = time_sig ? MODE_NIGHT : MODE_DAY;
    assign enter_ped = (mode_next == MODE_PED) && (mode != MODE_PED);
    // Emergency holds the counter at zero so clearance is timed from the last request.
    assign cnt_clr   = (mode_next != mode) || emg_req;

`ifdef TRAFFIC_PED_LATCH_EN
    logic ped_latch;

    assign ped_pend = ped_latch || (ped_req && (mode != MODE_PED));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_latch <= 1'b0;
        end else if (enter_ped) begin
            ped_latch <= 1'b0;
        end else if (ped_req && (mode != MODE_PED)) begin
            ped_latch <= 1'b1;
        end
    end
`else
    assign ped_pend = ped_req;
`endif

    always_comb begin
        mode_next = mode;
        if (emg_req) begin
            mode_next = MODE_EMG;
        end else begin
            case (mode)
                MODE_EMG: begin
                    if (dwell_cnt >= EmgLast) begin
                        mode_next = ped_pend ? MODE_PED : base;
                    end
                end
                MODE_PED: begin
                    if (dwell_cnt == PedLast) begin
                        mode_next = base;
                    end
                end
                default: begin
                    if (dwell_cnt >= DwellLast) begin
                        mode_next = ped_pend ? MODE_PED : base;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= MODE_DAY;
            mode_change <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            mode        <= mode_next;
            mode_change <= (mode_next != mode);
            ped_ack     <= enter_ped;
        end
    end

    traffic_dwell_counter #(
        .W (CNT_W)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .cnt (dwell_cnt)
    );

endmodule
